instr_fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of the CPU control FSM.
//  - Owns the PC and reads one instruction word from instruction memory over a req/ack handshake.
//  - Latches the word into the instruction register (IR) and raises en1 to release the controller from Fetch.
//  - Splits the IR into opcode/rd/rs/imm fields for the controller and datapath.
//  - Driven by the controller's en_fetch_pulse, en_pc_pulse and pc_ctrl.

---
 rtl/instr_fetch_unit.sv | 105 ++++++++++
 tb/tb_instr_fetch_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads one word over a req/ack handshake,
// latches it into the IR, and decodes the IR into opcode/rd/rs/imm fields.
module instr_fetch_unit #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_fetch_pulse,
    input  logic               en_pc_pulse,
    input  logic [1:0]         pc_ctrl,
    output logic               mem_req,
    output logic [PC_W-1:0]    mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_ack,
    output logic               en1,
    output logic [3:0]         opcode,
    output logic [1:0]         rd,
    output logic [1:0]         rs,
    output logic [7:0]         imm,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               fetch_err
);

    // Handshake: mem_req is a level held from the first REQ cycle until the
    // edge that samples mem_ack=1 (or the timeout); mem_addr is stable throughout.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [7:0]           tmo_cnt;
    logic [PC_W-1:0]      addr_q;
    logic [INSTR_W-1:0]   ir;

    assign mem_addr = addr_q;
    assign opcode   = ir[15:12];
    assign rd       = ir[11:10];
    assign rs       = ir[9:8];
    assign imm      = ir[7:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tmo_cnt   <= 8'd0;
            addr_q    <= '0;
            ir        <= '0;
            pc        <= '0;
            mem_req   <= 1'b0;
            busy      <= 1'b0;
            en1       <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            // The jump target uses the IR as it stood before this edge.
            if (en_pc_pulse) begin
                case (pc_ctrl)
                    2'b01:   pc <= pc + PC_W'(1);
                    2'b10:   pc <= PC_W'(ir[7:0]);
                    2'b11:   pc <= '0;
                    default: pc <= pc;
                endcase
            end

            case (state)
                IDLE, DONE: begin
                    if (en_fetch_pulse) begin
                        state     <= REQ;
                        mem_req   <= 1'b1;
                        busy      <= 1'b1;
                        addr_q    <= pc;
                        en1       <= 1'b0;
                        fetch_err <= 1'b0;
                        tmo_cnt   <= 8'd0;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        ir      <= mem_rdata;
                        en1     <= 1'b1;
                        state   <= DONE;
                        mem_req <= 1'b0;
                        busy    <= 1'b0;
                    end else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
                        fetch_err <= 1'b1;
                        state     <= IDLE;
                        mem_req   <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed plus randomized bench for instr_fetch_unit against a transaction-level
// model of PC, IR, en1 and fetch_err, with a memory responder of programmable wait.
module tb_instr_fetch_unit;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_fetch_pulse = 1'b0;
    logic        en_pc_pulse = 1'b0;
    logic [1:0]  pc_ctrl = 2'b00;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        en1;
    logic [3:0]  opcode;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic [7:0]  imm;
    logic [7:0]  pc;
    logic        busy;
    logic        fetch_err;

    logic        resp_ack = 1'b0;
    logic        spur_ack = 1'b0;
    logic [15:0] resp_data = 16'h0;
    logic [15:0] spur_data = 16'h0;
    int          resp_wait = 0;
    logic [15:0] mem [256];

    assign mem_ack   = resp_ack | spur_ack;
    assign mem_rdata = spur_ack ? spur_data : resp_data;

    int          checks = 0;
    int          errors = 0;

    int          pc_m = 0;
    int          addr_m = 0;
    logic [15:0] ir_m = 16'h0;
    logic        en1_m = 1'b0;
    logic        err_m = 1'b0;

    instr_fetch_unit #(.PC_W(8), .INSTR_W(16), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .en_fetch_pulse(en_fetch_pulse), .en_pc_pulse(en_pc_pulse), .pc_ctrl(pc_ctrl),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .en1(en1), .opcode(opcode), .rd(rd), .rs(rs), .imm(imm),
        .pc(pc), .busy(busy), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Memory responder: acks resp_wait cycles into a request; never when the wait is large.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            resp_ack = 1'b0;
            if (mem_req === 1'b1) begin
                if (cnt == resp_wait) begin
                    resp_ack  = 1'b1;
                    resp_data = mem[mem_addr];
                end
                cnt++;
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int next_pc(input int p, input logic [1:0] op, input logic [15:0] ir);
        case (op)
            2'b01:   return (p + 1) % 256;
            2'b10:   return int'(ir[7:0]);
            2'b11:   return 0;
            default: return p;
        endcase
    endfunction

    task automatic check_outputs();
        chk("en1", en1, en1_m);
        chk("fetch_err", fetch_err, err_m);
        chk("opcode", opcode, ir_m[15:12]);
        chk("rd", rd, ir_m[11:10]);
        chk("rs", rs, ir_m[9:8]);
        chk("imm", imm, ir_m[7:0]);
        chk("pc", pc, pc_m);
        chk("mem_addr", mem_addr, addr_m);
        chk("mem_req_idle", mem_req, 0);
        chk("busy_idle", busy, 0);
    endtask

    task automatic model_reset();
        pc_m = 0; addr_m = 0; ir_m = 16'h0; en1_m = 1'b0; err_m = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge where mem_req is seen low again.
    task automatic do_fetch(input int w, input logic do_pc, input logic [1:0] op, input logic extra);
        int hi;
        int hi_exp;
        addr_m    = pc_m;
        resp_wait = w;
        en_fetch_pulse = 1'b1; en_pc_pulse = do_pc; pc_ctrl = op;
        @(negedge clk);
        en_fetch_pulse = 1'b0; en_pc_pulse = 1'b0;
        if (do_pc) pc_m = next_pc(pc_m, op, ir_m);
        en1_m = 1'b0; err_m = 1'b0;
        chk("req_rise", mem_req, 1);
        chk("busy_rise", busy, 1);
        chk("req_addr", mem_addr, addr_m);
        chk("en1_clr", en1, 0);
        chk("err_clr", fetch_err, 0);
        chk("pc_same_edge", pc, pc_m);
        hi = 1;
        while (hi < 40) begin
            if (extra && hi == 2) begin
                en_fetch_pulse = 1'b1; en_pc_pulse = 1'b1; pc_ctrl = 2'b01;
            end
            @(negedge clk);
            if (extra && hi == 2) begin
                en_fetch_pulse = 1'b0; en_pc_pulse = 1'b0;
                pc_m = (pc_m + 1) % 256;
            end
            if (mem_req !== 1'b1) break;
            hi++;
            chk("addr_stable", mem_addr, addr_m);
        end
        if (w < TIMEOUT) begin
            ir_m = mem[addr_m]; en1_m = 1'b1; hi_exp = w + 1;
        end else begin
            err_m = 1'b1; hi_exp = TIMEOUT;
        end
        chk("req_cycles", hi, hi_exp);
        check_outputs();
    endtask

    task automatic do_pc_op(input logic [1:0] op);
        en_pc_pulse = 1'b1; pc_ctrl = op;
        @(negedge clk);
        en_pc_pulse = 1'b0;
        pc_m = next_pc(pc_m, op, ir_m);
        check_outputs();
    endtask

    task automatic spurious_ack(input logic [15:0] d);
        spur_ack = 1'b1; spur_data = d;
        @(negedge clk);
        spur_ack = 1'b0;
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h2A05;
        mem[1] = 16'h5C00;

        // Reset state
        rst = 1'b0;
        @(negedge clk);
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Zero-wait fetch with a same-edge PC increment
        do_fetch(0, 1'b1, 2'b01, 1'b0);
        chk("t1_opcode", opcode, 4'h2);
        chk("t1_imm", imm, 8'h05);

        // Three wait cycles
        do_fetch(3, 1'b0, 2'b00, 1'b0);
        chk("t2_rd", rd, 2'd3);

        // No ack: timeout, IR unchanged; next fetch clears fetch_err
        do_fetch(1000, 1'b0, 2'b00, 1'b0);
        chk("t3_opcode_kept", opcode, 4'h5);
        spurious_ack(16'hDEAD);
        mem[1] = 16'h10F0;
        do_fetch(0, 1'b0, 2'b00, 1'b0);

        // PC jump, wrap, clear, hold
        do_pc_op(2'b10);
        chk("t4_jump", pc, 8'hF0);
        mem[8'hF0] = 16'h30FF;
        do_fetch(1, 1'b0, 2'b00, 1'b0);
        do_pc_op(2'b10);
        chk("t4_ff", pc, 8'hFF);
        do_pc_op(2'b01);
        chk("t4_wrap", pc, 8'h00);
        do_pc_op(2'b01);
        do_pc_op(2'b11);
        chk("t4_clear", pc, 8'h00);
        do_pc_op(2'b00);

        // Fetch pulse during REQ and spurious ack in DONE are ignored
        do_fetch(5, 1'b1, 2'b01, 1'b1);
        spurious_ack(16'hBEEF);

        for (int i = 0; i < 40; i++) begin
            int w;
            if ($urandom_range(0, 3) == 0) begin
                do_pc_op(2'($urandom_range(0, 3)));
            end else begin
                w = $urandom_range(0, 17);
                do_fetch(w, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                         (w >= 3) && ($urandom_range(0, 1) == 1));
            end
        end

        // Asynchronous reset in the middle of a request
        mem[pc_m] = 16'hA5A5;
        do_fetch(0, 1'b1, 2'b01, 1'b0);
        resp_wait = 1000;
        en_fetch_pulse = 1'b1;
        @(negedge clk);
        en_fetch_pulse = 1'b0;
        chk("t6_req", mem_req, 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("t6_req_drop", mem_req, 0);
        chk("t6_busy_drop", busy, 0);
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        spurious_ack(16'h7777);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
